alub_operand_pipe: RTL and testbench
====================================

# alub_operand_pipe

Registered, parametrised ALU/address-ALU B-operand selector for the z180 datapath. It OR-combines up to NSRC one-hot-selected register sources into a data operand, with byte-shaping modes, and into an address operand. It buffers the result in a 2-entry skid FIFO behind a valid/ready handshake, so the sequencer can stall the ALU stage without dropping a selected operand. It also counts malformed (non-one-hot) selects for debug.

## Interface
- DW, 16, operand width; must be even, ≥ 8
- NSRC, 12, number of source ports
- ADDR_MASK, NSRC'hFFE, bit i = 1 lets source i drive the address operand
- CNT_W, 8, width of malformed-select counter
- clkc  in  1  clock, all state on rising edge
- resetb  in  1  synchronous, active-low reset
- src_bus  in  NSRC*DW  flattened sources, source i at bits [i*DW +: DW]
- sel  in  NSRC  source select, one-hot expected
- mode  in  2  00 pass, 01 replicate upper half, 10 zero-extend lower half, 11 swap halves
- in_valid  in  1  sel/mode/src_bus valid this cycle
- in_ready  out  1  pipe can accept
- alub_out  out  DW  shaped data operand (head entry)
- addb_out  out  DW  address operand (head entry)
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head entry
- sel_err  out  1  sticky: a malformed select was accepted
- err_cnt  out  CNT_W  saturating count of malformed accepted selects

## Operation
- Accept = in_valid & in_ready; pop = out_valid & out_ready.
- On accept, compute combinationally and write into the FIFO tail:
  - raw = OR over i of (sel[i] ? src_i : 0).
  - addr = OR over i of ((sel[i] & ADDR_MASK[i]) ? src_i : 0). Mode is never applied to addr.
- Data shaping, with H = DW/2:
  - 01 gives {raw[DW-1:H], raw[DW-1:H]}.
  - 10 gives {H'0, raw[H-1:0]}.
  - 11 gives {raw[H-1:0], raw[DW-1:H]}.
- Malformed select means sel == 0 or popcount(sel) > 1. Such a select is still accepted.
  - sel == 0 yields both operands 0.
  - Multi-hot yields the bitwise OR of the selected sources.
  - Any malformed accept sets sel_err and increments err_cnt; err_cnt saturates at all-ones.
  - Only resetb clears sel_err and err_cnt.
- FIFO: 2 entries, circular pointers wrapping 1→0, plus a 2-bit count.
  - in_ready = (count != 2). It depends on registered state only, with no combinational path from out_ready.
  - Accept and pop in the same cycle leave count unchanged: the head advances and the tail is written.
  - Accept when count == 0 is not bypassed; data appears next cycle.
- Reset (resetb low at a clock edge, including mid-transfer):
  - count 0, pointers 0, out_valid 0, in_ready 1 in the following cycle.
  - alub_out and addb_out 0; sel_err 0; err_cnt 0.
  - Entries in flight are discarded.

## Timing
- Latency is 1 cycle: an accept at edge N gives out_valid = 1 with its operands after edge N.
- Throughput is 1 operand/cycle while out_ready = 1.
- With out_ready held 0, two accepts fill the FIFO and in_ready falls after the second accept edge.
- On the first pop after that, in_ready rises in the next cycle.
- alub_out and addb_out are driven from the head register and are stable while out_valid & !out_ready.
- When count == 0, the outputs hold their last value and out_valid = 0.
- sel_err and err_cnt update on the same edge as the malformed accept.

## Structure
- The shared package holds:
  - mode encodings ALUB_M_PASS, ALUB_M_REPH, ALUB_M_ZXL, ALUB_M_SWAP;
  - z180 source index constants (AF=0, BC=1, DE=2, HL=3, IX=4, IY=5, SP=6, DIN=7, IO=8, TMP=9, PC=10, ADR=11);
  - the default ADDR_MASK value.
- One sub-module, alub_skid_fifo (depth 2, width 2*DW), holds the storage and handshake.
- The selection and shaping logic stays in the top module.

## Test plan
- BC=16'h1234 selected, mode 00, out_ready=1 → the next cycle gives alub_out 16'h1234, addb_out 16'h1234, out_valid 1, sel_err 0.
- Per-mode checks on the same source, taken from the HL port:
  - src 16'hA55A, mode 01 → 16'hA5A5.
  - src 16'hA55A, mode 10 → 16'h005A.
  - src 16'hA55A, mode 11 → 16'h5AA5.
  - addb_out stays 16'hA55A in every mode.
- AF selected (ADDR_MASK bit 0 = 0), value 16'hBEEF → alub_out 16'hBEEF, addb_out 16'h0000.
- Back-pressure:
  - Hold out_ready=0 and offer three operands 1, 2, 3 → in_ready drops after the second accept.
  - Release out_ready → outputs 1, 2, 3 in order with no loss or duplication.
- Malformed selects:
  - sel=0 → operand 0, err_cnt 1.
  - sel = BC|DE with 16'h0F00 and 16'h00F0 → 16'h0FF0, err_cnt 2, sel_err 1.
  - 300 malformed accepts → err_cnt saturates at 8'hFF.
- Assert resetb low with the FIFO full and out_ready=0 → the next cycle shows out_valid 0, in_ready 1, outputs 0, err_cnt 0.

Source files
------------

// File: rtl/alub_operand_pipe_pkg.sv
// Shared definitions for the z180 ALU/address-ALU B-operand pipe:
// shaping modes, register-source indices and the default address-source mask.
package alub_operand_pipe_pkg;

    typedef enum logic [1:0] {
        ALUB_M_PASS = 2'b00,
        ALUB_M_REPH = 2'b01,
        ALUB_M_ZXL  = 2'b10,
        ALUB_M_SWAP = 2'b11
    } alub_mode_e;

    localparam int SRC_AF  = 0;
    localparam int SRC_BC  = 1;
    localparam int SRC_DE  = 2;
    localparam int SRC_HL  = 3;
    localparam int SRC_IX  = 4;
    localparam int SRC_IY  = 5;
    localparam int SRC_SP  = 6;
    localparam int SRC_DIN = 7;
    localparam int SRC_IO  = 8;
    localparam int SRC_TMP = 9;
    localparam int SRC_PC  = 10;
    localparam int SRC_ADR = 11;

    localparam int ALUB_NSRC_DFLT = 12;

    // AF is the only default source that never forms an address.
    localparam logic [ALUB_NSRC_DFLT-1:0] ALUB_ADDR_MASK_DFLT = 12'hFFE;

endpackage

// File: rtl/alub_operand_pipe_if.sv
// Operand-select request side and shaped-operand result side of the B-operand pipe.
// Both sides use valid/ready: a transfer happens on a rising clkc edge where valid and ready are both 1.
interface alub_operand_pipe_if #(
    parameter int DW    = 16,
    parameter int NSRC  = 12,
    parameter int CNT_W = 8
);
    logic [NSRC*DW-1:0] src_bus;
    logic [NSRC-1:0]    sel;
    logic [1:0]         mode;
    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      alub_out;
    logic [DW-1:0]      addb_out;
    logic               out_valid;
    logic               out_ready;
    logic               sel_err;
    logic [CNT_W-1:0]   err_cnt;

    modport master (
        output src_bus, sel, mode, in_valid, out_ready,
        input  in_ready, alub_out, addb_out, out_valid, sel_err, err_cnt
    );

    modport slave (
        input  src_bus, sel, mode, in_valid, out_ready,
        output in_ready, alub_out, addb_out, out_valid, sel_err, err_cnt
    );
endinterface

// File: rtl/alub_skid_fifo.sv
// Two-entry circular FIFO with registered ready; the read port shows the head entry,
// or the most recently popped entry while empty.
module alub_skid_fifo #(
    parameter int W = 32
) (
    input  logic         clkc,
    input  logic         resetb,
    input  logic [W-1:0] wdata,
    input  logic         wvalid,
    output logic         wready,
    output logic [W-1:0] rdata,
    output logic         rvalid,
    input  logic         rready
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign wready = (count != 2'd2);
    assign rvalid = (count != 2'd0);
    assign push   = wvalid & wready;
    assign pop    = rvalid & rready;

    // When empty the slot behind rd_ptr holds the last popped entry.
    assign rdata = rvalid ? mem[rd_ptr] : mem[~rd_ptr];

    always_ff @(posedge clkc) begin
        if (!resetb) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alub_operand_pipe.sv
// Registered B-operand selector: ORs one-hot-selected sources into a shaped data operand
// and a masked address operand, buffered in a two-entry FIFO; counts malformed selects.
module alub_operand_pipe
    import alub_operand_pipe_pkg::*;
#(
    parameter int              DW        = 16,
    parameter int              NSRC      = ALUB_NSRC_DFLT,
    parameter logic [NSRC-1:0] ADDR_MASK = NSRC'(ALUB_ADDR_MASK_DFLT),
    parameter int              CNT_W     = 8
) (
    input logic                clkc,
    input logic                resetb,
    alub_operand_pipe_if.slave bus
);
    localparam int H = DW / 2;

    logic [DW-1:0]    raw;
    logic [DW-1:0]    addr;
    logic [DW-1:0]    shaped;
    logic [2*DW-1:0]  head;
    logic             malformed;
    logic             accept;
    logic             sel_err_q;
    logic [CNT_W-1:0] err_cnt_q;

    always_comb begin
        raw  = '0;
        addr = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.sel[i]) begin
                raw = raw | bus.src_bus[i*DW +: DW];
            end
            if (bus.sel[i] && ADDR_MASK[i]) begin
                addr = addr | bus.src_bus[i*DW +: DW];
            end
        end
    end

    always_comb begin
        shaped = raw;
        case (alub_mode_e'(bus.mode))
            ALUB_M_REPH: shaped = {raw[DW-1:H], raw[DW-1:H]};
            ALUB_M_ZXL:  shaped = {{(DW-H){1'b0}}, raw[H-1:0]};
            ALUB_M_SWAP: shaped = {raw[H-1:0], raw[DW-1:H]};
            default:     shaped = raw;
        endcase
    end

    // x & (x-1) clears the lowest set bit, so a nonzero result means more than one bit set.
    assign malformed = (bus.sel == '0) || ((bus.sel & (bus.sel - NSRC'(1))) != '0);
    assign accept    = bus.in_valid & bus.in_ready;

    alub_skid_fifo #(
        .W(2*DW)
    ) u_fifo (
        .clkc   (clkc),
        .resetb (resetb),
        .wdata  ({shaped, addr}),
        .wvalid (bus.in_valid),
        .wready (bus.in_ready),
        .rdata  (head),
        .rvalid (bus.out_valid),
        .rready (bus.out_ready)
    );

    assign bus.alub_out = head[2*DW-1:DW];
    assign bus.addb_out = head[DW-1:0];

    always_ff @(posedge clkc) begin
        if (!resetb) begin
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else if (accept && malformed) begin
            sel_err_q <= 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.sel_err = sel_err_q;
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_alub_operand_pipe.sv
// Randomised and directed bench for alub_operand_pipe against a queue-based operand model.
module tb_alub_operand_pipe;
    import alub_operand_pipe_pkg::*;

    localparam int DW    = 16;
    localparam int NSRC  = 12;
    localparam int CNT_W = 8;

    logic clkc   = 1'b0;
    logic resetb = 1'b0;

    always #5 clkc = ~clkc;

    alub_operand_pipe_if #(.DW(DW), .NSRC(NSRC), .CNT_W(CNT_W)) bus ();

    alub_operand_pipe #(
        .DW        (DW),
        .NSRC      (NSRC),
        .ADDR_MASK (12'hFFE),
        .CNT_W     (CNT_W)
    ) dut (
        .clkc   (clkc),
        .resetb (resetb),
        .bus    (bus)
    );

    logic [DW-1:0]   srcs [NSRC];
    logic [2*DW-1:0] exp_q [$];
    logic [2*DW-1:0] last_val;
    logic [NSRC-1:0] addr_mask = 12'hFFE;
    int              exp_err;
    logic            exp_sel_err;
    int              n_checks;
    int              n_errors;

    // Reference: the data operand is the OR of chosen registers reshaped by halves,
    // the address operand is the OR of chosen address-capable registers.
    function automatic logic [2*DW-1:0] ref_ops(input logic [NSRC-1:0] s, input logic [1:0] m);
        logic [DW-1:0] raw;
        logic [DW-1:0] adr;
        logic [DW-1:0] dat;
        logic [7:0]    hi;
        logic [7:0]    lo;
        raw = '0;
        adr = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (s[i]) raw = raw | srcs[i];
            if (s[i] && addr_mask[i]) adr = adr | srcs[i];
        end
        hi = raw[15:8];
        lo = raw[7:0];
        case (m)
            2'd1:    dat = {hi, hi};
            2'd2:    dat = {8'h00, lo};
            2'd3:    dat = {lo, hi};
            default: dat = raw;
        endcase
        return {dat, adr};
    endfunction

    function automatic logic [2*DW-1:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : last_val;
    endfunction

    task automatic drive_srcs();
        for (int i = 0; i < NSRC; i++) bus.src_bus[i*DW +: DW] = srcs[i];
    endtask

    task automatic randomize_srcs();
        for (int i = 0; i < NSRC; i++) srcs[i] = DW'($urandom_range(0, 16'hFFFF));
    endtask

    // One clock with the model advanced from the inputs as driven before the edge.
    task automatic step();
        logic            acc;
        logic            pop;
        logic            bad;
        logic [2*DW-1:0] e;
        drive_srcs();
        acc = bus.in_valid && (exp_q.size() < 2);
        pop = bus.out_ready && (exp_q.size() > 0);
        e   = ref_ops(bus.sel, bus.mode);
        bad = ($countones(bus.sel) != 1);
        @(posedge clkc);
        #1;
        if (pop) last_val = exp_q.pop_front();
        if (acc) begin
            exp_q.push_back(e);
            if (bad) begin
                exp_sel_err = 1'b1;
                if (exp_err < 255) exp_err++;
            end
        end
    endtask

    task automatic do_reset();
        resetb        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sel       = '0;
        bus.mode      = 2'd0;
        @(posedge clkc);
        #1;
        exp_q.delete();
        last_val    = '0;
        exp_err     = 0;
        exp_sel_err = 1'b0;
        resetb      = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.alub_out !== 16'h0 || bus.addb_out !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_ops: alub=%h addb=%h want 0 0", bus.alub_out, bus.addb_out);
        end
        n_checks++;
        if (bus.sel_err !== 1'b0 || bus.err_cnt !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_err: sel_err=%b err_cnt=%h want 0 00", bus.sel_err, bus.err_cnt);
        end
    endtask

    task automatic test_pass_bc();
        randomize_srcs();
        srcs[SRC_BC]  = 16'h1234;
        bus.sel       = NSRC'(1) << SRC_BC;
        bus.mode      = ALUB_M_PASS;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.alub_out !== 16'h1234 || bus.addb_out !== 16'h1234
            || bus.sel_err !== 1'b0) begin
            n_errors++;
            $display("FAIL pass_bc: v=%b alub=%h addb=%h err=%b want 1 1234 1234 0",
                     bus.out_valid, bus.alub_out, bus.addb_out, bus.sel_err);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.alub_out !== 16'h1234) begin
            n_errors++;
            $display("FAIL hold_empty: v=%b alub=%h want 0 1234", bus.out_valid, bus.alub_out);
        end
    endtask

    task automatic test_modes();
        logic [DW-1:0] want [4];
        want[0] = 16'hA55A;
        want[1] = 16'hA5A5;
        want[2] = 16'h005A;
        want[3] = 16'h5AA5;
        bus.out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            randomize_srcs();
            srcs[SRC_HL] = 16'hA55A;
            bus.sel      = NSRC'(1) << SRC_HL;
            bus.mode     = 2'(m);
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.alub_out !== want[m] || bus.addb_out !== 16'hA55A) begin
                n_errors++;
                $display("FAIL mode_%0d: v=%b alub=%h addb=%h want 1 %h a55a",
                         m, bus.out_valid, bus.alub_out, bus.addb_out, want[m]);
            end
            step();
        end
    endtask

    task automatic test_af_no_addr();
        randomize_srcs();
        srcs[SRC_AF]  = 16'hBEEF;
        bus.sel       = NSRC'(1) << SRC_AF;
        bus.mode      = ALUB_M_PASS;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.alub_out !== 16'hBEEF || bus.addb_out !== 16'h0000) begin
            n_errors++;
            $display("FAIL af_addr: alub=%h addb=%h want beef 0000", bus.alub_out, bus.addb_out);
        end
        step();
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] obs [$];
        logic          sent3;
        randomize_srcs();
        bus.sel       = NSRC'(1) << SRC_DE;
        bus.mode      = ALUB_M_PASS;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        srcs[SRC_DE]  = 16'd1;
        step();
        srcs[SRC_DE] = 16'd2;
        step();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_full: in_ready=%b want 0", bus.in_ready);
        end
        srcs[SRC_DE] = 16'd3;
        step();
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.alub_out !== 16'd1) begin
            n_errors++;
            $display("FAIL bp_stall: in_ready=%b v=%b alub=%h want 0 1 0001",
                     bus.in_ready, bus.out_valid, bus.alub_out);
        end
        bus.out_ready = 1'b1;
        sent3 = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (sent3 && !bus.out_valid) break;
            if (bus.out_valid) obs.push_back(bus.alub_out);
            if (bus.in_valid && bus.in_ready) sent3 = 1'b1;
            step();
            if (sent3) bus.in_valid = 1'b0;
            if (cyc == 0) begin
                n_checks++;
                if (bus.in_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bp_rise: in_ready=%b want 1", bus.in_ready);
                end
            end
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (obs.size() != 3) begin
            n_errors++;
            $display("FAIL bp_count: got %0d operands want 3", obs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs[k] !== DW'(k + 1)) begin
                    n_errors++;
                    $display("FAIL bp_order_%0d: got %h want %h", k, obs[k], DW'(k + 1));
                end
            end
        end
    endtask

    task automatic test_malformed();
        do_reset();
        randomize_srcs();
        bus.sel       = '0;
        bus.mode      = ALUB_M_PASS;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.alub_out !== 16'h0 || bus.addb_out !== 16'h0 || bus.err_cnt !== 8'd1
            || bus.sel_err !== 1'b1) begin
            n_errors++;
            $display("FAIL sel_zero: alub=%h addb=%h cnt=%h err=%b want 0 0 01 1",
                     bus.alub_out, bus.addb_out, bus.err_cnt, bus.sel_err);
        end
        step();
        srcs[SRC_BC] = 16'h0F00;
        srcs[SRC_DE] = 16'h00F0;
        bus.sel      = (NSRC'(1) << SRC_BC) | (NSRC'(1) << SRC_DE);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.alub_out !== 16'h0FF0 || bus.addb_out !== 16'h0FF0 || bus.err_cnt !== 8'd2
            || bus.sel_err !== 1'b1) begin
            n_errors++;
            $display("FAIL sel_multi: alub=%h addb=%h cnt=%h err=%b want 0ff0 0ff0 02 1",
                     bus.alub_out, bus.addb_out, bus.err_cnt, bus.sel_err);
        end
        step();
    endtask

    task automatic test_saturate();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            randomize_srcs();
            bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) bus.sel = '0;
            else bus.sel = (NSRC'(1) << $urandom_range(0, 5)) | (NSRC'(1) << $urandom_range(6, 11));
            step();
            n_checks++;
            if (bus.err_cnt !== CNT_W'(exp_err) || bus.alub_out !== exp_head()[2*DW-1:DW]) begin
                n_errors++;
                $display("FAIL sat_%0d: cnt=%h alub=%h want %h %h",
                         k, bus.err_cnt, bus.alub_out, CNT_W'(exp_err), exp_head()[2*DW-1:DW]);
            end
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.err_cnt !== 8'hFF || bus.sel_err !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_final: cnt=%h err=%b want ff 1", bus.err_cnt, bus.sel_err);
        end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            randomize_srcs();
            bus.mode      = 2'($urandom_range(0, 3));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) bus.sel = NSRC'($urandom_range(0, 12'hFFF));
            else bus.sel = NSRC'(1) << $urandom_range(0, NSRC - 1);
            step();
            n_checks++;
            if (bus.in_ready !== (exp_q.size() < 2) || bus.out_valid !== (exp_q.size() > 0)) begin
                n_errors++;
                $display("FAIL rnd_hs_%0d: in_ready=%b v=%b want %b %b", k, bus.in_ready,
                         bus.out_valid, exp_q.size() < 2, exp_q.size() > 0);
            end
            n_checks++;
            if ({bus.alub_out, bus.addb_out} !== exp_head()) begin
                n_errors++;
                $display("FAIL rnd_ops_%0d: alub=%h addb=%h want %h", k, bus.alub_out,
                         bus.addb_out, exp_head());
            end
            n_checks++;
            if (bus.err_cnt !== CNT_W'(exp_err) || bus.sel_err !== exp_sel_err) begin
                n_errors++;
                $display("FAIL rnd_err_%0d: cnt=%h err=%b want %h %b", k, bus.err_cnt,
                         bus.sel_err, CNT_W'(exp_err), exp_sel_err);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        randomize_srcs();
        bus.sel       = NSRC'(1) << SRC_PC;
        bus.mode      = ALUB_M_SWAP;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) step();
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_full: in_ready=%b v=%b want 0 1", bus.in_ready, bus.out_valid);
        end
        resetb = 1'b0;
        @(posedge clkc);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.alub_out !== 16'h0
            || bus.addb_out !== 16'h0 || bus.err_cnt !== 8'h0 || bus.sel_err !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: v=%b rdy=%b alub=%h addb=%h cnt=%h err=%b want 0 1 0 0 0 0",
                     bus.out_valid, bus.in_ready, bus.alub_out, bus.addb_out, bus.err_cnt, bus.sel_err);
        end
        exp_q.delete();
        last_val     = '0;
        exp_err      = 0;
        exp_sel_err  = 1'b0;
        resetb       = 1'b1;
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_discard: v=%b want 0", bus.out_valid);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        exp_err       = 0;
        exp_sel_err   = 1'b0;
        last_val      = '0;
        bus.src_bus   = '0;
        bus.sel       = '0;
        bus.mode      = 2'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NSRC; i++) srcs[i] = '0;
        test_reset();
        test_pass_bc();
        test_modes();
        test_af_no_addr();
        test_back_pressure();
        test_malformed();
        test_saturate();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
